// File: rtl/blitter_pkg.sv
// Shared constants and drain-state encoding for the blitter write buffer.
package blitter_pkg;
    localparam int LINE_BYTES = 32;
    localparam int BURST_LEN  = 8;
    localparam int ADDR_W     = 26;
    localparam int TAG_W      = 21;

    typedef enum logic [1:0] {IDLE, REQ, DATA} drain_state_e;
endpackage

// File: rtl/blitter_line_buffer.sv
// One 32-byte line buffer: data words, per-byte valid mask, line tag and occupied flag.
module blitter_line_buffer
    import blitter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             write,
    input  logic             clear,
    input  logic [TAG_W-1:0] tag_in,
    input  logic [4:0]       offset,
    input  logic [7:0]       wbyte,
    input  logic [2:0]       beat,
    output logic [TAG_W-1:0] tag,
    output logic             occupied,
    output logic [31:0]      beat_data,
    output logic [3:0]       beat_mask
);
    logic [BURST_LEN-1:0][31:0] data;
    logic [LINE_BYTES-1:0]      mask;

    always_ff @(posedge clock) begin
        if (reset) begin
            mask     <= '0;
            occupied <= 1'b0;
            tag      <= '0;
        end else begin
            if (clear) begin
                mask     <= '0;
                occupied <= 1'b0;
            end
            // start opens a fresh line: the mask holds only the incoming byte
            if (start) begin
                tag      <= tag_in;
                occupied <= 1'b1;
                mask     <= LINE_BYTES'(1) << offset;
            end else if (write) begin
                mask[offset] <= 1'b1;
            end
        end
    end

    // Unmasked bytes are don't-care, so the data array carries no reset.
    always_ff @(posedge clock) begin
        if (start || write)
            data[offset[4:2]][{offset[1:0], 3'b000} +: 8] <= wbyte;
    end

    assign beat_data = data[beat];
    assign beat_mask = mask[{beat, 2'b00} +: 4];
endmodule

// File: rtl/blitter_write_buffer.sv
// Ping-pong byte-merging write buffer that drains full/flushed lines as 8-beat bursts.
// Optional BLIT_WRITE_STATS_EN adds saturating stat_lines / stat_stalls counters.
module blitter_write_buffer
    import blitter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [7:0]        write_data,
    input  logic              write_request,
    output logic              write_stall,
    input  logic              flush,
    output logic              idle,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_request,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_wready,
    input  logic              mem_ack,
`ifdef BLIT_WRITE_STATS_EN
    output logic [15:0]       stat_lines,
    output logic [15:0]       stat_stalls,
`endif
    input  logic              mem_complete
);
    drain_state_e state;
    logic         fill_sel;
    logic [2:0]   beat;

    logic [1:0]             occ, start, wr, clr;
    logic [1:0][TAG_W-1:0]  tag;
    logic [1:0][31:0]       rdata;
    logic [1:0][3:0]        rmask;

    logic fill_occ, tag_hit, drain_busy, accept, handoff_wr, handoff_flush, handoff;

    assign fill_occ      = occ[fill_sel];
    assign tag_hit       = tag[fill_sel] == write_address[ADDR_W-1:5];
    assign drain_busy    = state != IDLE;
    assign write_stall   = write_request && fill_occ && !tag_hit && drain_busy;
    assign accept        = write_request && !write_stall;
    assign handoff_wr    = accept && fill_occ && !tag_hit;
    assign handoff_flush = flush && fill_occ && !drain_busy && !accept;
    assign handoff       = handoff_wr || handoff_flush;

    // On a write handoff the incoming byte opens the buffer that is about to become fill.
    always_comb begin
        start = '0;
        wr    = '0;
        clr   = '0;
        if (accept && !fill_occ)          start[fill_sel]  = 1'b1;
        if (handoff_wr)                   start[~fill_sel] = 1'b1;
        if (accept && fill_occ && tag_hit) wr[fill_sel]    = 1'b1;
        if (state == DATA && mem_complete) clr[~fill_sel]  = 1'b1;
    end

    for (genvar i = 0; i < 2; i++) begin : g_buf
        blitter_line_buffer u_buf (
            .clock     (clock),
            .reset     (reset),
            .start     (start[i]),
            .write     (wr[i]),
            .clear     (clr[i]),
            .tag_in    (write_address[ADDR_W-1:5]),
            .offset    (write_address[4:0]),
            .wbyte     (write_data),
            .beat      (beat),
            .tag       (tag[i]),
            .occupied  (occ[i]),
            .beat_data (rdata[i]),
            .beat_mask (rmask[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            fill_sel    <= 1'b0;
            beat        <= '0;
            mem_request <= 1'b0;
            mem_address <= '0;
        end else begin
            if (handoff) fill_sel <= ~fill_sel;
            case (state)
                IDLE: if (handoff) begin
                    state       <= REQ;
                    mem_request <= 1'b1;
                    mem_address <= {tag[fill_sel], 5'b0};
                    beat        <= '0;
                end
                REQ: if (mem_ack) begin
                    state       <= DATA;
                    mem_request <= 1'b0;
                    if (mem_wready) beat <= beat + 3'd1;
                end
                DATA: begin
                    if (mem_wready)   beat  <= beat + 3'd1;
                    if (mem_complete) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_write = mem_request;
    assign mem_wdata = rdata[~fill_sel];
    assign mem_wmask = rmask[~fill_sel];
    assign idle      = ~|occ && state == IDLE;

`ifdef BLIT_WRITE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_lines  <= '0;
            stat_stalls <= '0;
        end else begin
            if (state == DATA && mem_complete && stat_lines != 16'hFFFF)
                stat_lines <= stat_lines + 16'd1;
            if (write_stall && stat_stalls != 16'hFFFF)
                stat_stalls <= stat_stalls + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_blitter_write_buffer.sv
// Scoreboard bench: stimulus queues expected bursts, a memory-model monitor checks each one.
module tb_blitter_write_buffer;
    logic        clock = 1'b0;
    logic        reset;
    logic [25:0] write_address;
    logic [7:0]  write_data;
    logic        write_request;
    logic        write_stall;
    logic        flush;
    logic        idle;
    logic [25:0] mem_address;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wready;
    logic        mem_ack;
    logic        mem_complete;
`ifdef BLIT_WRITE_STATS_EN
    logic [15:0] stat_lines, stat_stalls;
`endif

    always #5 clock = ~clock;

    blitter_write_buffer dut (
        .clock         (clock),
        .reset         (reset),
        .write_address (write_address),
        .write_data    (write_data),
        .write_request (write_request),
        .write_stall   (write_stall),
        .flush         (flush),
        .idle          (idle),
        .mem_address   (mem_address),
        .mem_request   (mem_request),
        .mem_write     (mem_write),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_wready    (mem_wready),
        .mem_ack       (mem_ack),
`ifdef BLIT_WRITE_STATS_EN
        .stat_lines    (stat_lines),
        .stat_stalls   (stat_stalls),
`endif
        .mem_complete  (mem_complete)
    );

    typedef struct {
        logic [25:0]      addr;
        logic [7:0][31:0] data;
        logic [7:0][3:0]  mask;
    } burst_t;

    burst_t exp_q[$];
    int compared = 0, mismatched = 0;
    int nbeats = 0, lines_done = 0, stall_cycles = 0;
    logic active = 1'b0, wready_en = 1'b1;
    logic [25:0]      cur_addr;
    logic [7:0][31:0] got_data;
    logic [7:0][3:0]  got_mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] m);
        for (int i = 0; i < 4; i++) bmask[i*8 +: 8] = {8{m[i]}};
    endfunction

    function automatic burst_t mk(input logic [25:0] a);
        burst_t e;
        e.addr = a;
        e.data = '0;
        e.mask = '0;
        return e;
    endfunction

    task automatic score();
        burst_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_burst: got addr %h expected none", cur_addr);
            return;
        end
        e = exp_q.pop_front();
        check("burst_addr", 32'(cur_addr), 32'(e.addr));
        for (int b = 0; b < 8; b++) begin
            check($sformatf("beat%0d_mask@%h", b, e.addr), 32'(got_mask[b]), 32'(e.mask[b]));
            check($sformatf("beat%0d_data@%h", b, e.addr),
                  got_data[b] & bmask(e.mask[b]), e.data[b] & bmask(e.mask[b]));
        end
    endtask

    // Memory model + monitor: acks, pulls 8 beats when allowed, then completes.
    initial begin
        mem_ack = 1'b0; mem_wready = 1'b0; mem_complete = 1'b0;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0; mem_wready = 1'b0; mem_complete = 1'b0;
            if (reset) begin
                active = 1'b0;
                nbeats = 0;
            end else if (!active && mem_request) begin
                active   = 1'b1;
                cur_addr = mem_address;
                nbeats   = 0;
                mem_ack  = 1'b1;
            end else if (active && nbeats < 8) begin
                if (wready_en) begin
                    mem_wready       = 1'b1;
                    got_data[nbeats] = mem_wdata;
                    got_mask[nbeats] = mem_wmask;
                    nbeats++;
                end
            end else if (active) begin
                mem_complete = 1'b1;
                active       = 1'b0;
                lines_done++;
                score();
            end
        end
    end

    task automatic wr(input logic [25:0] a, input logic [7:0] d, output int stalls, output int rel);
        int t = 0;
        stalls = 0;
        write_address = a; write_data = d; write_request = 1'b1;
        #1;
        while (write_stall && t < 200) begin
            stalls++; stall_cycles++;
            @(posedge clock); #1;
            t++;
        end
        rel = lines_done;
        if (t >= 200) check("wr_stall_timeout", 32'(t), 32'd0);
        @(posedge clock); #1;
        write_request = 1'b0;
    endtask

    task automatic do_flush(input string name);
        int t = 0;
        flush = 1'b1;
        @(posedge clock); #1;
        while (!idle && t < 300) begin
            @(posedge clock); #1;
            t++;
        end
        flush = 1'b0;
        check(name, 32'(idle), 32'd1);
    endtask

    initial begin
        burst_t e;
        int s, r, base, seen, t, lines_at_rst;
        reset = 1'b1; write_request = 1'b0; write_address = '0; write_data = '0; flush = 1'b0;
        repeat (3) @(posedge clock); #1;
        check("rst_write_stall", 32'(write_stall), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_mem_request", 32'(mem_request), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // full line
        e = mk(26'h100);
        for (int i = 0; i < 8; i++) begin
            e.data[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            e.mask[i] = 4'hF;
        end
        exp_q.push_back(e);
        for (int i = 0; i < 32; i++) wr(26'h100 + 26'(i), 8'(i), s, r);
        do_flush("t1_idle");

        // single byte partial line
        e = mk(26'h200); e.data[1] = 32'h0000AA00; e.mask[1] = 4'b0010;
        exp_q.push_back(e);
        wr(26'h205, 8'hAA, s, r);
        do_flush("t2_idle");

        // stall while the drain buffer is stuck waiting for wready
        wready_en = 1'b0;
        e = mk(26'h000); e.data[0] = 32'h13121110; e.mask[0] = 4'hF; exp_q.push_back(e);
        e = mk(26'h020); e.data[0] = 32'h00000021; e.mask[0] = 4'b0001; exp_q.push_back(e);
        e = mk(26'h040); e.data[1] = 32'h00004100; e.mask[1] = 4'b0010; exp_q.push_back(e);
        for (int i = 0; i < 4; i++) wr(26'(i), 8'h10 + 8'(i), s, r);
        wr(26'h020, 8'h21, s, r);
        base = lines_done;
        fork
            wr(26'h045, 8'h41, s, r);
            begin repeat (12) @(posedge clock); wready_en = 1'b1; end
        join
        check("t3_stalled", 32'(s != 0), 32'd1);
        check("t3_release_after_complete", 32'(r), 32'(base + 1));
        do_flush("t3_idle");

        // same-byte overwrite
        e = mk(26'h300); e.data[0] = 32'h00000022; e.mask[0] = 4'b0001;
        exp_q.push_back(e);
        wr(26'h300, 8'h11, s, r);
        wr(26'h300, 8'h22, s, r);
        do_flush("t4_idle");

        // reset in the middle of a burst; that burst is not expected
        for (int i = 0; i < 16; i++) wr(26'h480 + 26'(i), 8'h80 + 8'(i), s, r);
        flush = 1'b1;
        t = 0;
        while (nbeats < 4 && t < 200) begin @(posedge clock); #1; t++; end
        check("t5_reached_beat4", 32'(nbeats >= 4), 32'd1);
        reset = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clock); #1;
        check("t5_mem_request", 32'(mem_request), 32'd0);
        check("t5_idle", 32'(idle), 32'd1);
        reset = 1'b0;
        stall_cycles = 0;
        lines_at_rst = lines_done;
        seen = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (mem_request) seen++;
        end
        check("t5_no_restart", 32'(seen), 32'd0);
        check("t5_no_beats", 32'(nbeats), 32'd0);
        e = mk(26'h400); e.data[0] = 32'h000000CC; e.mask[0] = 4'b0001;
        exp_q.push_back(e);
        wr(26'h400, 8'hCC, s, r);
        do_flush("t5_clean_idle");

        repeat (5) @(posedge clock); #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef BLIT_WRITE_STATS_EN
        check("stat_lines", 32'(stat_lines), 32'(lines_done - lines_at_rst));
        check("stat_stalls", 32'(stat_stalls), 32'(stall_cycles));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end
endmodule
